// File: rtl/ta_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ta_seq_pkg
//  Description : Shared state and fault encodings for the TA enable sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ta_seq_pkg;

  localparam int DAC_W = 16;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PWR_WAIT  = 3'd1;
  localparam state_t ST_RAMP_UP   = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_RAMP_DOWN = 3'd4;
  localparam state_t ST_FAULT     = 3'd5;

  typedef logic [2:0] fault_t;
  localparam fault_t FLT_NONE       = 3'd0;
  localparam fault_t FLT_PG_TIMEOUT = 3'd1;
  localparam fault_t FLT_PG_LOST    = 3'd2;
  localparam fault_t FLT_EE         = 3'd3;
  localparam fault_t FLT_OPT        = 3'd4;
  localparam fault_t FLT_OC         = 3'd5;
  localparam fault_t FLT_WDOG       = 3'd6;

  // Highest-priority active cause; watchdog ranks below everything else.
  function automatic fault_t fault_pick(input logic oc, input logic opt, input logic ee,
                                        input logic pg_lost, input logic pg_to,
                                        input logic wdog);
    fault_t f;
    f = FLT_NONE;
    if (oc)           f = FLT_OC;
    else if (opt)     f = FLT_OPT;
    else if (ee)      f = FLT_EE;
    else if (pg_lost) f = FLT_PG_LOST;
    else if (pg_to)   f = FLT_PG_TIMEOUT;
    else if (wdog)    f = FLT_WDOG;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ta_ramp_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : ta_ramp_stepper
//  Description : Step timer and saturating DAC-code stepping toward a limit,
//                with a held step when the DAC write path is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module ta_ramp_stepper
  import ta_seq_pkg::*;
#(
  parameter int RAMP_DIV  = 2500,
  parameter int RAMP_STEP = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             dir_up_i,
  input  logic [DAC_W-1:0] cur_code_i,
  input  logic [DAC_W-1:0] limit_i,
  input  logic             dac_ready_i,
  output logic             step_done_o,
  output logic [DAC_W-1:0] step_code_o,
  output logic             at_limit_o
);

  localparam int TW = $clog2(RAMP_DIV);

  logic [TW-1:0]    timer_q, timer_d;
  logic             w_expired;
  logic [DAC_W:0]   w_sum;
  logic [DAC_W:0]   w_floor_plus;

  assign w_expired    = (timer_q == TW'(RAMP_DIV - 1));
  assign step_done_o  = en_i && w_expired && dac_ready_i;
  assign at_limit_o   = (cur_code_i == limit_i);
  assign w_sum        = {1'b0, cur_code_i} + (DAC_W+1)'(RAMP_STEP);
  assign w_floor_plus = {1'b0, limit_i} + (DAC_W+1)'(RAMP_STEP);

  // An expired timer parks at its terminal count until the DAC accepts.
  always_comb begin
    timer_d = timer_q;
    if (!en_i)              timer_d = '0;
    else if (!w_expired)    timer_d = timer_q + 1'b1;
    else if (dac_ready_i)   timer_d = '0;
  end

  always_comb begin
    step_code_o = limit_i;
    if (dir_up_i) begin
      if (w_sum < {1'b0, limit_i}) step_code_o = w_sum[DAC_W-1:0];
    end else begin
      if ({1'b0, cur_code_i} > w_floor_plus) step_code_o = cur_code_i - DAC_W'(RAMP_STEP);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) timer_q <= '0;
    else       timer_q <= timer_d;
  end

endmodule
`default_nettype wire

// File: rtl/ta_enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ta_enable_sequencer
//  Description : TA laser-driver bring-up/shutdown sequencer with power-good
//                qualification, DAC ramping and latched safety faults.
//                Optional keepalive watchdog: define TA_SEQ_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ta_enable_sequencer
  import ta_seq_pkg::*;
#(
  parameter int RAMP_DIV    = 2500,
  parameter int RAMP_STEP   = 64,
  parameter int PG_DEBOUNCE = 25,
  parameter int PG_TIMEOUT  = 250000
`ifdef TA_SEQ_WATCHDOG_EN
  ,parameter int WDOG_LIMIT = 25000000
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [DAC_W-1:0] target_current,
  input  logic             fault_clear,
  input  logic             pos_pwr_good,
  input  logic             neg_pwr_good,
  input  logic             ee_shutdown,
  input  logic             opt_shutdown,
  input  logic             over_current,
  input  logic             dac_ready,
`ifdef TA_SEQ_WATCHDOG_EN
  input  logic             keepalive,
`endif
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_update,
  output logic             laser_disable,
  output logic [2:0]       seq_state,
  output logic [2:0]       fault_code,
  output logic             ramp_busy
);

  localparam int DBW = $clog2(PG_DEBOUNCE + 1);
  localparam int TOW = $clog2(PG_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [DAC_W-1:0] dac_code_q, dac_code_d;
  logic             dac_update_q, dac_update_d;
  logic             laser_disable_q, laser_disable_d;
  fault_t           fault_code_q, fault_code_d;
  logic             ramp_busy_q, ramp_busy_d;
  logic [DBW-1:0]   db_q, db_d;
  logic [TOW-1:0]   to_q, to_d;
  logic             fpend_q, fpend_d;

  logic             w_pg_ok, w_driving, w_ramping, w_flt_hit, w_wdog_trip, w_commit;
  logic             w_step_done, w_at_limit;
  logic [DAC_W-1:0] w_step_code, w_limit;
  fault_t           w_cause;

  assign w_pg_ok   = pos_pwr_good && neg_pwr_good;
  assign w_driving = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
  assign w_ramping = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign w_cause   = fault_pick(over_current, opt_shutdown, ee_shutdown,
                                w_driving && !w_pg_ok,
                                (state_q == ST_PWR_WAIT) && (to_q == TOW'(PG_TIMEOUT - 1)),
                                w_wdog_trip);
  assign w_flt_hit = (w_driving || (state_q == ST_PWR_WAIT)) && (w_cause != FLT_NONE);
  // Ramping down toward zero once enable drops, otherwise toward the target.
  assign w_limit   = ((state_q == ST_RAMP_UP) || enable) ? target_current : '0;
  assign w_commit  = w_step_done && (state_d == state_q);

`ifdef TA_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_LIMIT + 1);
  logic [WDW-1:0] wd_q, wd_d;

  assign w_wdog_trip = w_driving && !keepalive && (wd_q == WDW'(WDOG_LIMIT - 1));

  always_comb begin
    wd_d = '0;
    if (w_driving && !keepalive) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign w_wdog_trip = 1'b0;
`endif

  ta_ramp_stepper #(
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_stepper (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (w_ramping && !w_at_limit),
    .dir_up_i    (state_q == ST_RAMP_UP),
    .cur_code_i  (dac_code_q),
    .limit_i     (w_limit),
    .dac_ready_i (dac_ready),
    .step_done_o (w_step_done),
    .step_code_o (w_step_code),
    .at_limit_o  (w_at_limit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      dac_code_q      <= '0;
      dac_update_q    <= 1'b0;
      laser_disable_q <= 1'b1;
      fault_code_q    <= FLT_NONE;
      ramp_busy_q     <= 1'b0;
      db_q            <= '0;
      to_q            <= '0;
      fpend_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      dac_code_q      <= dac_code_d;
      dac_update_q    <= dac_update_d;
      laser_disable_q <= laser_disable_d;
      fault_code_q    <= fault_code_d;
      ramp_busy_q     <= ramp_busy_d;
      db_q            <= db_d;
      to_q            <= to_d;
      fpend_q         <= fpend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_flt_hit) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:      if (enable) state_d = ST_PWR_WAIT;
        ST_PWR_WAIT: begin
          if (!enable)                                         state_d = ST_IDLE;
          else if (w_pg_ok && (db_q == DBW'(PG_DEBOUNCE - 1))) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!enable || (target_current < dac_code_q)) state_d = ST_RAMP_DOWN;
          else if (w_at_limit)                          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!enable || (target_current < dac_code_q)) state_d = ST_RAMP_DOWN;
          else if (target_current > dac_code_q)         state_d = ST_RAMP_UP;
        end
        ST_RAMP_DOWN: begin
          if (w_at_limit) begin
            if (enable)         state_d = ST_RUN;
            else if (dac_ready) state_d = ST_IDLE;
          end else if (enable && (target_current > dac_code_q)) begin
            state_d = ST_RAMP_UP;
          end
        end
        ST_FAULT: begin
          // Power-goods are re-qualified in PWR_WAIT, so only the shutdown inputs gate the clear.
          if (fault_clear && !enable && !over_current && !opt_shutdown && !ee_shutdown && !fpend_q)
            state_d = ST_IDLE;
        end
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dac_code_d      = dac_code_q;
    dac_update_d    = 1'b0;
    fault_code_d    = fault_code_q;
    fpend_d         = fpend_q;
    laser_disable_d = !((state_d == ST_RAMP_UP) || (state_d == ST_RUN) || (state_d == ST_RAMP_DOWN));
    ramp_busy_d     = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    db_d            = ((state_q == ST_PWR_WAIT) && (state_d == ST_PWR_WAIT) && w_pg_ok) ? db_q + 1'b1 : '0;
    to_d            = ((state_q == ST_PWR_WAIT) && (state_d == ST_PWR_WAIT)) ? to_q + 1'b1 : '0;
    if (w_flt_hit) begin
      dac_code_d   = '0;
      fault_code_d = w_cause;
      // The DAC has never been written before RAMP_UP, so a PWR_WAIT fault needs no zero write.
      if (w_driving) begin
        if (dac_ready) dac_update_d = 1'b1;
        else           fpend_d      = 1'b1;
      end
    end else if (w_commit) begin
      dac_code_d   = w_step_code;
      dac_update_d = 1'b1;
    end else if (state_q == ST_FAULT) begin
      if (fpend_q && dac_ready) begin
        dac_update_d = 1'b1;
        fpend_d      = 1'b0;
      end
      if (state_d == ST_IDLE) fault_code_d = FLT_NONE;
    end else if (state_d == ST_IDLE) begin
      dac_code_d = '0;
    end
  end

  assign dac_code      = dac_code_q;
  assign dac_update    = dac_update_q;
  assign laser_disable = laser_disable_q;
  assign seq_state     = state_q;
  assign fault_code    = fault_code_q;
  assign ramp_busy     = ramp_busy_q;

endmodule
`default_nettype wire
